inst_loader: RTL and testbench

Boot-time program loader between the RS-232C byte receiver (i232c) and the instruction memory inside top.
- Assembles received bytes, MSB first, into 32-bit words and writes them to consecutive instruction-memory addresses starting at 0.
- Stops loading when the end marker 32'hffffffff arrives, then raises cpu_start.
- Once loaded, forwards every further received byte to the CPU input path as program data.

---
 rtl/inst_loader_pkg.sv | 11 +
 rtl/inst_loader_byte_assembler.sv | 38 +++
 rtl/inst_loader.sv | 110 +++++++++++
 tb/tb_inst_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package inst_loader_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        DONE = 1'b1
    } state_t;

    localparam logic [31:0] END_MARKER_DEFAULT = 32'hffffffff;

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Edge-detects the receiver strobe and packs bytes MSB first into words.
module inst_loader_byte_assembler (
    input  logic        CLK,
    input  logic        XRST,
    input  logic        en,
    input  logic [7:0]  rx_data,
    input  logic        rx_changed,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic        rx_changed_q;
    logic [23:0] shift_q;
    logic [1:0]  byte_idx_q;

    // A strobe held high for several cycles is still one byte.
    assign byte_valid = rx_changed & ~rx_changed_q;
    assign byte_data  = rx_data;
    assign word       = {shift_q, rx_data};
    assign word_valid = en & byte_valid & (byte_idx_q == 2'd3);

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            rx_changed_q <= 1'b0;
            shift_q      <= '0;
            byte_idx_q   <= '0;
        end else begin
            rx_changed_q <= rx_changed;
            if (en && byte_valid) begin
                shift_q    <= {shift_q[15:0], rx_data};
                byte_idx_q <= byte_idx_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/inst_loader.sv
// Loads a program from the serial byte stream into instruction memory,
// then starts the CPU and forwards later bytes as program input.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = 14,
    parameter logic [31:0] END_MARKER = END_MARKER_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  XRST,
    input  logic [7:0]            rx_data,
    input  logic                  rx_changed,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_start,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic [7:0]            in_data,
    output logic                  in_valid
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    state_t                state_q, state_d;
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic [31:0]           word;
    logic                  word_valid;

    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [31:0]           wdata_d;
    logic                  ovf_d;
    logic [ADDR_WIDTH:0]   cnt_d;
    logic [7:0]            in_data_d;
    logic                  in_valid_d;

    inst_loader_byte_assembler u_asm (
        .CLK        (CLK),
        .XRST       (XRST),
        .en         (state_q == LOAD),
        .rx_data    (rx_data),
        .rx_changed (rx_changed),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .word       (word),
        .word_valid (word_valid)
    );

    assign cpu_start = (state_q == DONE);

    always_comb begin
        state_d    = state_q;
        we_d       = 1'b0;
        addr_d     = imem_addr;
        wdata_d    = imem_wdata;
        ovf_d      = overflow;
        cnt_d      = word_count;
        in_data_d  = in_data;
        in_valid_d = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (word_valid) begin
                    if (word == END_MARKER) begin
                        state_d = DONE;
                    // Top count bit set means every address is used.
                    end else if (!word_count[ADDR_WIDTH]) begin
                        we_d    = 1'b1;
                        addr_d  = word_count[ADDR_WIDTH-1:0];
                        wdata_d = word;
                        cnt_d   = word_count + CNT_ONE;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (byte_valid) begin
                    in_valid_d = 1'b1;
                    in_data_d  = byte_data;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            state_q    <= LOAD;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            overflow   <= 1'b0;
            word_count <= '0;
            in_data    <= '0;
            in_valid   <= 1'b0;
        end else begin
            state_q    <= state_d;
            imem_we    <= we_d;
            imem_addr  <= addr_d;
            imem_wdata <= wdata_d;
            overflow   <= ovf_d;
            word_count <= cnt_d;
            in_data    <= in_data_d;
            in_valid   <= in_valid_d;
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader with a queue-based reference model.
module tb_inst_loader;

    logic        CLK = 1'b0;
    logic        XRST = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_changed = 1'b0;

    logic        b_we, s_we;
    logic [13:0] b_addr;
    logic [1:0]  s_addr;
    logic [31:0] b_wdata, s_wdata;
    logic        b_start, s_start;
    logic        b_ovf, s_ovf;
    logic [14:0] b_cnt;
    logic [2:0]  s_cnt;
    logic [7:0]  b_in_data, s_in_data;
    logic        b_in_valid, s_in_valid;

    inst_loader dut (
        .CLK(CLK), .XRST(XRST), .rx_data(rx_data), .rx_changed(rx_changed),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .cpu_start(b_start), .overflow(b_ovf), .word_count(b_cnt),
        .in_data(b_in_data), .in_valid(b_in_valid)
    );

    inst_loader #(.ADDR_WIDTH(2)) dut_s (
        .CLK(CLK), .XRST(XRST), .rx_data(rx_data), .rx_changed(rx_changed),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .cpu_start(s_start), .overflow(s_ovf), .word_count(s_cnt),
        .in_data(s_in_data), .in_valid(s_in_valid)
    );

    always #5 CLK = ~CLK;

    int          n_chk = 0;
    int          n_err = 0;
    bit          chk_en = 0;

    // Model state: index 0 = 16K-word memory, index 1 = 4-word memory.
    int          cap [2] = '{16384, 4};
    int          m_cnt [2];
    bit          m_we [2];
    int          m_addr [2];
    logic [31:0] m_wdata [2];
    bit          m_ovf [2];
    bit          m_done;
    logic [7:0]  m_in_data;
    bit          m_in_valid;
    logic [7:0]  m_q [$];

    logic [31:0] wlog_b [$];
    int          alog_b [$];
    logic [31:0] wlog_s [$];
    int          alog_s [$];
    logic [7:0]  ilog [$];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_we[i] = 0; m_addr[i] = 0;
            m_wdata[i] = 0; m_ovf[i] = 0;
        end
        m_done = 0; m_in_data = 0; m_in_valid = 0;
        m_q.delete();
        wlog_b.delete(); alog_b.delete();
        wlog_s.delete(); alog_s.delete();
        ilog.delete();
    endtask

    // Effect of a clock edge at which a byte was (or was not) accepted.
    task automatic model_apply(bit acc, logic [7:0] b);
        logic [31:0] w;
        for (int i = 0; i < 2; i++) m_we[i] = 0;
        m_in_valid = 0;
        if (acc) begin
            if (!m_done) begin
                m_q.push_back(b);
                if (m_q.size() == 4) begin
                    w = {m_q[0], m_q[1], m_q[2], m_q[3]};
                    m_q.delete();
                    if (w == 32'hffffffff) m_done = 1;
                    else begin
                        for (int i = 0; i < 2; i++) begin
                            if (m_cnt[i] < cap[i]) begin
                                m_we[i] = 1; m_addr[i] = m_cnt[i];
                                m_wdata[i] = w; m_cnt[i]++;
                            end else m_ovf[i] = 1;
                        end
                    end
                end
            end else begin
                m_in_valid = 1;
                m_in_data = b;
            end
        end
    endtask

    task automatic tick(bit acc, logic [7:0] b);
        @(posedge CLK);
        #1;
        model_apply(acc, b);
    endtask

    task automatic send(logic [7:0] b, int hold);
        rx_data = b;
        rx_changed = 1'b1;
        tick(1, b);
        for (int k = 1; k < hold; k++) tick(0, 8'h00);
        rx_changed = 1'b0;
        tick(0, 8'h00);
    endtask

    task automatic send_word(logic [31:0] w, int hold);
        for (int k = 3; k >= 0; k--) send(w[8*k +: 8], hold);
    endtask

    task automatic do_reset();
        XRST = 1'b0;
        rx_changed = 1'b0;
        rx_data = 8'h00;
        model_reset();
        tick(0, 8'h00);
        tick(0, 8'h00);
        XRST = 1'b1;
        tick(0, 8'h00);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("b_we", 32'(b_we), 32'(m_we[0]));
            chk("b_addr", 32'(b_addr), m_addr[0]);
            chk("b_wdata", b_wdata, m_wdata[0]);
            chk("b_start", 32'(b_start), 32'(m_done));
            chk("b_ovf", 32'(b_ovf), 32'(m_ovf[0]));
            chk("b_cnt", 32'(b_cnt), m_cnt[0]);
            chk("b_in_valid", 32'(b_in_valid), 32'(m_in_valid));
            chk("b_in_data", 32'(b_in_data), 32'(m_in_data));
            chk("s_we", 32'(s_we), 32'(m_we[1]));
            chk("s_addr", 32'(s_addr), m_addr[1]);
            chk("s_wdata", s_wdata, m_wdata[1]);
            chk("s_start", 32'(s_start), 32'(m_done));
            chk("s_ovf", 32'(s_ovf), 32'(m_ovf[1]));
            chk("s_cnt", 32'(s_cnt), m_cnt[1]);
            chk("s_in_valid", 32'(s_in_valid), 32'(m_in_valid));
            chk("s_in_data", 32'(s_in_data), 32'(m_in_data));
            if (b_we) begin wlog_b.push_back(b_wdata); alog_b.push_back(int'(b_addr)); end
            if (s_we) begin wlog_s.push_back(s_wdata); alog_s.push_back(int'(s_addr)); end
            if (b_in_valid) ilog.push_back(b_in_data);
        end
    end

    initial begin
        #2;
        XRST = 1'b0;
        model_reset();
        chk_en = 1;
        do_reset();
        chk("t0_cnt", 32'(b_cnt), 32'd0);

        // 1: one word then marker
        send_word(32'h00112233, 1);
        send_word(32'hffffffff, 1);
        tick(0, 8'h00);
        chk("t1_nwr", wlog_b.size(), 1);
        chk("t1_addr", alog_b.size() > 0 ? alog_b[0] : -1, 0);
        chk("t1_data", wlog_b.size() > 0 ? wlog_b[0] : 0, 32'h00112233);
        chk("t1_cnt", 32'(b_cnt), 1);
        chk("t1_start", 32'(b_start), 1);

        // 2: three words, back-to-back strobes
        do_reset();
        send_word(32'h01020304, 1);
        send_word(32'h05060708, 1);
        send_word(32'h090a0b0c, 1);
        send_word(32'hffffffff, 1);
        tick(0, 8'h00);
        chk("t2_nwr", wlog_b.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_addr", alog_b.size() > i ? alog_b[i] : -1, i);
        end
        chk("t2_d0", wlog_b.size() > 0 ? wlog_b[0] : 0, 32'h01020304);
        chk("t2_d1", wlog_b.size() > 1 ? wlog_b[1] : 0, 32'h05060708);
        chk("t2_d2", wlog_b.size() > 2 ? wlog_b[2] : 0, 32'h090a0b0c);
        chk("t2_cnt", 32'(b_cnt), 3);

        // 3: empty program, then pass-through
        do_reset();
        send_word(32'hffffffff, 1);
        chk("t3_start", 32'(b_start), 1);
        send_word(32'h01020304, 2);
        tick(0, 8'h00);
        chk("t3_nwr", wlog_b.size(), 0);
        chk("t3_cnt", 32'(b_cnt), 0);
        chk("t3_nin", ilog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t3_in", ilog.size() > i ? 32'(ilog[i]) : 0, i + 1);
        end

        // 4: long strobes, plus a near-marker word
        do_reset();
        send_word(32'haabbccdd, 5);
        send_word(32'hfffffffe, 1);
        tick(0, 8'h00);
        chk("t4_nwr", wlog_b.size(), 2);
        chk("t4_d0", wlog_b.size() > 0 ? wlog_b[0] : 0, 32'haabbccdd);
        chk("t4_d1", wlog_b.size() > 1 ? wlog_b[1] : 0, 32'hfffffffe);
        chk("t4_start", 32'(b_start), 0);

        // 5: overflow of the 4-word instance
        do_reset();
        for (int i = 0; i < 5; i++) send_word(32'h11110000 + i, 1);
        chk("t5_ovf", 32'(s_ovf), 1);
        send_word(32'hffffffff, 1);
        tick(0, 8'h00);
        chk("t5_scnt", 32'(s_cnt), 4);
        chk("t5_sstart", 32'(s_start), 1);
        chk("t5_nwr", wlog_s.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t5_addr", alog_s.size() > i ? alog_s[i] : -1, i);
        end
        chk("t5_bcnt", 32'(b_cnt), 5);
        chk("t5_bovf", 32'(b_ovf), 0);

        // 6: reset mid-word discards partial bytes
        do_reset();
        send(8'hde, 1);
        send(8'had, 1);
        do_reset();
        send_word(32'h12345678, 1);
        send_word(32'hffffffff, 1);
        tick(0, 8'h00);
        chk("t6_nwr", wlog_b.size(), 1);
        chk("t6_addr", alog_b.size() > 0 ? alog_b[0] : -1, 0);
        chk("t6_data", wlog_b.size() > 0 ? wlog_b[0] : 0, 32'h12345678);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
